// File: rtl/adc_scan_sequencer.sv
// Walks the enabled ADC channels once per scan period, running the capture
// engine's address/enable/ack handshake and storing each result per channel.
module adc_scan_sequencer #(
  parameter int CLK_HZ         = 25000000,
  parameter int SCAN_HZ        = 100,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int DATA_W         = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        ch_mask,
  output logic [2:0]        cap_address,
  output logic              cap_en,
  input  logic              cap_ready,
  input  logic [DATA_W-1:0] cap_data,
  output logic              cap_ack,
  input  logic [2:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        ch_valid,
  output logic              scan_done,
  output logic              fault,
  output logic              overrun
);

  localparam int PERIOD   = CLK_HZ / SCAN_HZ;
  localparam int TICK_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(PERIOD - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CAPTURE, ACK, NEXT} state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [7:0]          scan_mask, scan_mask_nxt, mask_rem;
  logic [2:0]          cur_ch, cur_ch_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [TO_W-1:0]     to_cnt, to_nxt;
  logic [2:0]          addr_nxt;
  logic                cap_en_nxt, cap_ack_nxt, done_nxt, fault_nxt, overrun_nxt;
  logic                wr_en;
  logic [DATA_W-1:0]   result [8];

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign tick = en && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) tick_cnt <= '0;
    else                    tick_cnt <= tick_cnt + TICK_W'(1);
  end

  always_comb begin
    state_nxt     = state;
    scan_mask_nxt = scan_mask;
    cur_ch_nxt    = cur_ch;
    settle_nxt    = settle_cnt;
    to_nxt        = to_cnt;
    addr_nxt      = cap_address;
    cap_en_nxt    = cap_en;
    cap_ack_nxt   = cap_ack;
    done_nxt      = 1'b0;
    fault_nxt     = fault;
    overrun_nxt   = overrun | (tick && (state != IDLE));
    wr_en         = 1'b0;
    mask_rem      = scan_mask & ~(8'b1 << cur_ch);
    if (!en) begin
      state_nxt   = IDLE;
      cap_en_nxt  = 1'b0;
      cap_ack_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && (ch_mask != 8'h00)) begin
            scan_mask_nxt = ch_mask;
            cur_ch_nxt    = lowest_bit(ch_mask);
            state_nxt     = SELECT;
          end
        end
        SELECT: begin
          addr_nxt   = cur_ch;
          settle_nxt = SETTLE_LOAD;
          state_nxt  = SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            cap_en_nxt = 1'b1;
            to_nxt     = '0;
            state_nxt  = CAPTURE;
          end else begin
            settle_nxt = settle_cnt - SETTLE_W'(1);
          end
        end
        CAPTURE: begin
          if (cap_ready) begin
            wr_en       = 1'b1;
            cap_ack_nxt = 1'b1;
            cap_en_nxt  = 1'b0;
            to_nxt      = '0;
            state_nxt   = ACK;
          end else if (to_cnt == TO_LAST) begin
            fault_nxt  = 1'b1;
            cap_en_nxt = 1'b0;
            state_nxt  = NEXT;
          end else begin
            to_nxt = to_cnt + TO_W'(1);
          end
        end
        ACK: begin
          // Four-phase: ack stays up until the engine withdraws ready
          if (!cap_ready) begin
            cap_ack_nxt = 1'b0;
            state_nxt   = NEXT;
          end else if (to_cnt == TO_LAST) begin
            fault_nxt   = 1'b1;
            cap_ack_nxt = 1'b0;
            state_nxt   = NEXT;
          end else begin
            to_nxt = to_cnt + TO_W'(1);
          end
        end
        NEXT: begin
          scan_mask_nxt = mask_rem;
          if (mask_rem != 8'h00) begin
            cur_ch_nxt = lowest_bit(mask_rem);
            state_nxt  = SELECT;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scan_mask   <= '0;
      cur_ch      <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      cap_address <= '0;
      cap_en      <= 1'b0;
      cap_ack     <= 1'b0;
      scan_done   <= 1'b0;
      fault       <= 1'b0;
      overrun     <= 1'b0;
      ch_valid    <= '0;
      rd_data     <= '0;
      for (int i = 0; i < 8; i++) result[i] <= '0;
    end else begin
      state       <= state_nxt;
      scan_mask   <= scan_mask_nxt;
      cur_ch      <= cur_ch_nxt;
      settle_cnt  <= settle_nxt;
      to_cnt      <= to_nxt;
      cap_address <= addr_nxt;
      cap_en      <= cap_en_nxt;
      cap_ack     <= cap_ack_nxt;
      scan_done   <= done_nxt;
      fault       <= fault_nxt;
      overrun     <= overrun_nxt;
      // Read samples the bank before this edge's write lands
      rd_data     <= result[rd_ch];
      if (wr_en) begin
        result[cur_ch]   <= cap_data;
        ch_valid[cur_ch] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural capture engine
// driven on the falling edge; P=100 cycles, settle=4, timeout=50.
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  ch_mask;
  logic [2:0]  cap_address;
  logic        cap_en;
  logic        cap_ready = 1'b0;
  logic [11:0] cap_data = 12'h000;
  logic        cap_ack;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic [7:0]  ch_valid;
  logic        scan_done;
  logic        fault;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int excl_viol = 0;

  logic [11:0] model_val [8];
  int          model_delay = 20;
  int          never_ch = -1;
  int          wait_cnt = 0;

  adc_scan_sequencer #(
    .CLK_HZ(1000), .SCAN_HZ(10), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50), .DATA_W(12)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask),
    .cap_address(cap_address), .cap_en(cap_en), .cap_ready(cap_ready),
    .cap_data(cap_data), .cap_ack(cap_ack), .rd_ch(rd_ch), .rd_data(rd_data),
    .ch_valid(ch_valid), .scan_done(scan_done), .fault(fault), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Capture engine model: ready after model_delay cycles of cap_en, dropped on ack
  always @(negedge clk) begin
    if (cap_en && cap_ack) excl_viol++;
    if (rst) begin
      cap_ready = 1'b0;
      wait_cnt  = 0;
    end else if (cap_ready) begin
      if (cap_ack) cap_ready = 1'b0;
    end else if (cap_en && (int'(cap_address) != never_ch)) begin
      wait_cnt++;
      if (wait_cnt >= model_delay) begin
        cap_ready = 1'b1;
        cap_data  = model_val[cap_address];
        wait_cnt  = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ch_mask = 8'h00; rd_ch = 3'd0; never_ch = -1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ch_mask = 8'h00; rd_ch = 3'd0;
    step();
    total++; if (cap_address !== 3'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", cap_address); end
    total++; if (cap_en !== 1'b0) begin bad++; $display("FAIL reset_cap_en: got %b want 0", cap_en); end
    total++; if (cap_ack !== 1'b0) begin bad++; $display("FAIL reset_cap_ack: got %b want 0", cap_ack); end
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL reset_rd_data: got %h want 000", rd_data); end
    total++; if (ch_valid !== 8'h00) begin bad++; $display("FAIL reset_ch_valid: got %h want 00", ch_valid); end
    total++; if ({scan_done, fault, overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {scan_done, fault, overrun}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int en_k = -1, ack_k = -1, sd1 = -1, sd2 = -1, sd_cnt = 0, addr_bad = 0;
    do_reset();
    model_val[0] = 12'h4A7; model_delay = 20; ch_mask = 8'h01; en = 1'b1;
    for (int k = 1; k <= 230; k++) begin
      step();
      if (cap_en && en_k < 0) en_k = k;
      if (cap_ack && ack_k < 0) ack_k = k;
      if (scan_done) begin
        sd_cnt++;
        if (sd1 < 0) sd1 = k; else if (sd2 < 0) sd2 = k;
      end
      if ((cap_en || cap_ack) && cap_address != 3'd0) addr_bad++;
    end
    total++; if (en_k !== 105) begin bad++; $display("FAIL single_cap_en_cycle: got %0d want 105", en_k); end
    total++; if (ack_k !== 125) begin bad++; $display("FAIL single_ack_cycle: got %0d want 125", ack_k); end
    total++; if (sd1 !== 127) begin bad++; $display("FAIL single_done_cycle: got %0d want 127", sd1); end
    total++; if (sd2 !== 227) begin bad++; $display("FAIL single_done_period: got %0d want 227", sd2); end
    total++; if (sd_cnt !== 2) begin bad++; $display("FAIL single_done_count: got %0d want 2", sd_cnt); end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL single_addr: got %0d bad cycles want 0", addr_bad); end
    total++; if (ch_valid !== 8'h01) begin bad++; $display("FAIL single_ch_valid: got %h want 01", ch_valid); end
    rd_ch = 3'd0;
    step();
    total++; if (rd_data !== 12'h4A7) begin bad++; $display("FAIL single_result: got %h want 4a7", rd_data); end
  endtask

  task automatic test_multi();
    logic [2:0]  seq [$];
    logic [2:0]  exp_ch  [3] = '{3'd2, 3'd5, 3'd7};
    logic [11:0] exp_val [3] = '{12'h2A5, 12'h5A5, 12'h7A5};
    logic [2:0]  held_addr = 3'd0;
    logic        prev_en = 1'b0, held = 1'b0;
    int addr2_k = -1, done_k = -1, unstable = 0;
    do_reset();
    model_val[2] = 12'h2A5; model_val[5] = 12'h5A5; model_val[7] = 12'h7A5;
    model_delay = 10; ch_mask = 8'b1010_0100; en = 1'b1;
    for (int k = 1; k <= 180; k++) begin
      step();
      if (cap_address == 3'd2 && addr2_k < 0) addr2_k = k;
      if (cap_en && !prev_en) seq.push_back(cap_address);
      prev_en = cap_en;
      if (cap_en || cap_ack) begin
        if (held && cap_address != held_addr) unstable++;
        held = 1'b1; held_addr = cap_address;
      end else begin
        held = 1'b0;
      end
      if (scan_done && done_k < 0) done_k = k;
    end
    total++; if (addr2_k !== 101) begin bad++; $display("FAIL multi_tick_to_addr: got %0d want 101", addr2_k); end
    total++; if (seq.size() !== 3) begin bad++; $display("FAIL multi_channel_count: got %0d want 3", seq.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [2:0] got;
      got = (i < seq.size()) ? seq[i] : 3'bxxx;
      total++; if (got !== exp_ch[i]) begin bad++; $display("FAIL multi_order[%0d]: got %0d want %0d", i, got, exp_ch[i]); end
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL multi_addr_stable: got %0d changes want 0", unstable); end
    total++; if (done_k !== 151) begin bad++; $display("FAIL multi_done_cycle: got %0d want 151", done_k); end
    total++; if (ch_valid !== 8'hA4) begin bad++; $display("FAIL multi_ch_valid: got %h want a4", ch_valid); end
    for (int i = 0; i < 3; i++) begin
      rd_ch = exp_ch[i];
      step();
      total++; if (rd_data !== exp_val[i]) begin bad++; $display("FAIL multi_result[%0d]: got %h want %h", exp_ch[i], rd_data, exp_val[i]); end
    end
  endtask

  task automatic test_timeout();
    int en3_k = -1, fault_k = -1, sd_k = -1;
    do_reset();
    model_val[0] = 12'h111; model_val[3] = 12'h333; model_delay = 5;
    never_ch = 3; ch_mask = 8'h09; en = 1'b1;
    for (int k = 1; k <= 190; k++) begin
      step();
      if (cap_en && cap_address == 3'd3 && en3_k < 0) en3_k = k;
      if (fault && fault_k < 0) fault_k = k;
      if (scan_done && sd_k < 0) sd_k = k;
    end
    total++; if (en3_k !== 117) begin bad++; $display("FAIL timeout_ch3_en: got %0d want 117", en3_k); end
    total++; if (fault_k - en3_k !== 50) begin bad++; $display("FAIL timeout_delay: got %0d want 50", fault_k - en3_k); end
    total++; if (sd_k !== 168) begin bad++; $display("FAIL timeout_done: got %0d want 168", sd_k); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", fault); end
    total++; if (ch_valid !== 8'h01) begin bad++; $display("FAIL timeout_ch_valid: got %h want 01", ch_valid); end
    rd_ch = 3'd3;
    step();
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL timeout_result3: got %h want 000", rd_data); end
    rd_ch = 3'd0;
    step();
    total++; if (rd_data !== 12'h111) begin bad++; $display("FAIL timeout_result0: got %h want 111", rd_data); end
  endtask

  task automatic test_overrun();
    logic [2:0] seq [$];
    logic [2:0] exp_ch [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic prev_en = 1'b0;
    int ov_k = -1, sd_k = -1, sd_cnt = 0, restart_k = -1;
    do_reset();
    for (int i = 0; i < 4; i++) model_val[i] = 12'(12'h0C0 + i);
    model_delay = 30; ch_mask = 8'h0F; en = 1'b1;
    for (int k = 1; k <= 310; k++) begin
      step();
      if (overrun && ov_k < 0) ov_k = k;
      if (scan_done) begin sd_cnt++; if (sd_k < 0) sd_k = k; end
      if (cap_en && !prev_en) begin
        seq.push_back(cap_address);
        if (seq.size() == 5) restart_k = k;
      end
      prev_en = cap_en;
    end
    total++; if (ov_k !== 200) begin bad++; $display("FAIL overrun_cycle: got %0d want 200", ov_k); end
    total++; if (sd_k !== 248) begin bad++; $display("FAIL overrun_done_cycle: got %0d want 248", sd_k); end
    total++; if (sd_cnt !== 1) begin bad++; $display("FAIL overrun_done_count: got %0d want 1", sd_cnt); end
    total++; if (seq.size() !== 5) begin bad++; $display("FAIL overrun_channel_count: got %0d want 5", seq.size()); end
    for (int i = 0; i < 5; i++) begin
      logic [2:0] got;
      got = (i < seq.size()) ? seq[i] : 3'bxxx;
      total++; if (got !== exp_ch[i]) begin bad++; $display("FAIL overrun_order[%0d]: got %0d want %0d", i, got, exp_ch[i]); end
    end
    total++; if (restart_k !== 305) begin bad++; $display("FAIL overrun_restart: got %0d want 305", restart_k); end
  endtask

  task automatic test_abort();
    int sd_cnt = 0, en_k = -1, sd_k = -1;
    do_reset();
    model_val[1] = 12'h1B1; model_delay = 20; ch_mask = 8'h02; en = 1'b1;
    for (int k = 1; k <= 110; k++) step();
    total++; if (cap_en !== 1'b1) begin bad++; $display("FAIL abort_pre_cap_en: got %b want 1", cap_en); end
    en = 1'b0;
    step();
    total++; if ({cap_en, cap_ack} !== 2'b00) begin bad++; $display("FAIL abort_cap_en: got %b want 00", {cap_en, cap_ack}); end
    for (int k = 1; k <= 60; k++) begin
      step();
      if (scan_done) sd_cnt++;
    end
    total++; if (sd_cnt !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", sd_cnt); end
    total++; if (ch_valid !== 8'h00) begin bad++; $display("FAIL abort_ch_valid: got %h want 00", ch_valid); end
    rd_ch = 3'd1;
    step();
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL abort_result: got %h want 000", rd_data); end
    en = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      step();
      if (cap_en && en_k < 0) en_k = k;
      if (scan_done && sd_k < 0) sd_k = k;
    end
    total++; if (en_k !== 105) begin bad++; $display("FAIL abort_restart_en: got %0d want 105", en_k); end
    total++; if (sd_k !== 127) begin bad++; $display("FAIL abort_restart_done: got %0d want 127", sd_k); end
    step();
    total++; if (rd_data !== 12'h1B1) begin bad++; $display("FAIL abort_restart_result: got %h want 1b1", rd_data); end
  endtask

  task automatic test_reset_mid_ack();
    int k = 0, ack1 = -1, ack2 = -1;
    do_reset();
    model_val[5] = 12'h4A7; model_delay = 20; ch_mask = 8'h20; rd_ch = 3'd5; en = 1'b1;
    while (k < 200 && !cap_ack) begin step(); k++; end
    if (cap_ack) ack1 = k;
    total++; if (ack1 !== 125) begin bad++; $display("FAIL rdport_ack1: got %0d want 125", ack1); end
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL rdport_same_edge: got %h want 000", rd_data); end
    step(); k++;
    total++; if (rd_data !== 12'h4A7) begin bad++; $display("FAIL rdport_next_cycle: got %h want 4a7", rd_data); end
    model_val[5] = 12'h5B8;
    while (k < 350 && !cap_ack) begin step(); k++; end
    if (cap_ack) ack2 = k;
    total++; if (ack2 !== 225) begin bad++; $display("FAIL rdport_ack2: got %0d want 225", ack2); end
    total++; if (rd_data !== 12'h4A7) begin bad++; $display("FAIL rdport_old_value: got %h want 4a7", rd_data); end
    rst = 1'b1;
    step();
    total++; if (cap_address !== 3'd0) begin bad++; $display("FAIL midack_addr: got %0d want 0", cap_address); end
    total++; if ({cap_en, cap_ack} !== 2'b00) begin bad++; $display("FAIL midack_handshake: got %b want 00", {cap_en, cap_ack}); end
    total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL midack_rd_data: got %h want 000", rd_data); end
    total++; if (ch_valid !== 8'h00) begin bad++; $display("FAIL midack_ch_valid: got %h want 00", ch_valid); end
    total++; if ({scan_done, fault, overrun} !== 3'b000) begin bad++; $display("FAIL midack_flags: got %b want 000", {scan_done, fault, overrun}); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_val[i] = 12'h000;
    test_reset();
    test_single();
    test_multi();
    test_timeout();
    test_overrun();
    test_abort();
    test_reset_mid_ack();
    total++; if (excl_viol !== 0) begin bad++; $display("FAIL en_ack_exclusive: got %0d overlaps want 0", excl_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
